// File: rtl/cheshire_eoc_monitor.sv
`default_nettype none
// ============================================================================
// Module   : cheshire_eoc_monitor
// Brief    : Snoops the register-bus write channel for the end-of-computation
//            write, latches the exit code and flags done / watchdog timeout.
// Revision : 1.0 - initial release
// ============================================================================

module cheshire_eoc_monitor #(
    parameter int unsigned          AddrWidth = 48,
    parameter int unsigned          DataWidth = 32,
    parameter logic [AddrWidth-1:0] EocAddr   = '0,
    parameter int unsigned          CntWidth  = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   arm_i,
    input  logic                   clear_i,
    input  logic [CntWidth-1:0]    timeout_cycles_i,
    input  logic                   snoop_valid_i,
    input  logic                   snoop_ready_i,
    input  logic                   snoop_write_i,
    input  logic [AddrWidth-1:0]   snoop_addr_i,
    input  logic [DataWidth-1:0]   snoop_wdata_i,
    input  logic [DataWidth/8-1:0] snoop_be_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   timeout_o,
    output logic [DataWidth-2:0]   exit_code_o,
    output logic [CntWidth-1:0]    cycles_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_DONE    = 2'd2,
        S_TIMEOUT = 2'd3
    } state_t;

    state_t r_state;

    logic              w_eoc;
    logic [CntWidth:0] w_cnt_inc;
    logic              w_expire;
    logic              w_sat;
    logic              w_unused_be;

    assign w_eoc = snoop_valid_i & snoop_ready_i & snoop_write_i
                 & (snoop_addr_i == EocAddr)
                 & snoop_be_i[0] & snoop_wdata_i[0];

    // One extra bit so the expiry compare stays correct once the counter saturates.
    assign w_cnt_inc   = {1'b0, cycles_o} + {{CntWidth{1'b0}}, 1'b1};
    assign w_expire    = (timeout_cycles_i != '0) && (w_cnt_inc >= {1'b0, timeout_cycles_i});
    assign w_sat       = &cycles_o;
    assign w_unused_be = ^snoop_be_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            timeout_o   <= 1'b0;
            exit_code_o <= '0;
            cycles_o    <= '0;
        end else if (clear_i) begin
            r_state     <= S_IDLE;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            timeout_o   <= 1'b0;
            exit_code_o <= '0;
            cycles_o    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (arm_i) begin
                        r_state  <= S_ARMED;
                        busy_o   <= 1'b1;
                        cycles_o <= '0;
                    end
                end
                S_ARMED: begin
                    // EOC outranks the watchdog; the counter freezes on either exit.
                    if (w_eoc) begin
                        r_state     <= S_DONE;
                        busy_o      <= 1'b0;
                        done_o      <= 1'b1;
                        exit_code_o <= snoop_wdata_i[DataWidth-1:1];
                    end else if (w_expire) begin
                        r_state   <= S_TIMEOUT;
                        busy_o    <= 1'b0;
                        timeout_o <= 1'b1;
                    end else if (!w_sat) begin
                        cycles_o <= w_cnt_inc[CntWidth-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cheshire_eoc_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_cheshire_eoc_monitor
// Brief    : Directed self-checking bench with a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_cheshire_eoc_monitor;

    localparam logic [47:0] EOC  = 48'h0000_0300_0004;
    localparam int          CMAX = 255;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        arm = 1'b0;
    logic        clr = 1'b0;
    logic [7:0]  tmo = 8'd0;
    logic        s_valid = 1'b0;
    logic        s_ready = 1'b0;
    logic        s_write = 1'b0;
    logic [47:0] s_addr = 48'd0;
    logic [31:0] s_wdata = 32'd0;
    logic [3:0]  s_be = 4'd0;

    logic        busy, done, tout;
    logic [30:0] exit_code;
    logic [7:0]  cycles;

    int n_cmp = 0;
    int n_err = 0;

    cheshire_eoc_monitor #(
        .AddrWidth (48),
        .DataWidth (32),
        .EocAddr   (EOC),
        .CntWidth  (8)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .arm_i            (arm),
        .clear_i          (clr),
        .timeout_cycles_i (tmo),
        .snoop_valid_i    (s_valid),
        .snoop_ready_i    (s_ready),
        .snoop_write_i    (s_write),
        .snoop_addr_i     (s_addr),
        .snoop_wdata_i    (s_wdata),
        .snoop_be_i       (s_be),
        .busy_o           (busy),
        .done_o           (done),
        .timeout_o        (tout),
        .exit_code_o      (exit_code),
        .cycles_o         (cycles)
    );

    always #5 clk = ~clk;

    // Reference model: phase flags plus a plain integer cycle count.
    logic        m_busy, m_done, m_tout;
    logic [30:0] m_exit;
    int          m_cycles;

    function automatic logic is_eoc();
        return s_valid && s_ready && s_write && (s_addr == EOC) && s_be[0] && s_wdata[0];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || clr) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_tout <= 1'b0;
            m_exit <= '0;   m_cycles <= 0;
        end else if (m_busy) begin
            if (is_eoc()) begin
                m_busy <= 1'b0; m_done <= 1'b1; m_exit <= s_wdata[31:1];
            end else if (tmo != 0 && m_cycles + 1 >= int'(tmo)) begin
                m_busy <= 1'b0; m_tout <= 1'b1;
            end else if (m_cycles < CMAX) begin
                m_cycles <= m_cycles + 1;
            end
        end else if (!m_done && !m_tout && arm) begin
            m_busy <= 1'b1; m_cycles <= 0;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("model.busy",    64'(busy),      64'(m_busy));
            check("model.done",    64'(done),      64'(m_done));
            check("model.timeout", 64'(tout),      64'(m_tout));
            check("model.exit",    64'(exit_code), 64'(m_exit));
            check("model.cycles",  64'(cycles),    64'(m_cycles));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic v, input logic r, input logic w,
                       input logic [47:0] a, input logic [31:0] d, input logic [3:0] be);
        s_valid = v; s_ready = r; s_write = w; s_addr = a; s_wdata = d; s_be = be;
        tick(1);
        s_valid = 1'b0; s_ready = 1'b0; s_write = 1'b0; s_addr = '0; s_wdata = '0; s_be = '0;
    endtask

    task automatic do_arm();
        arm = 1'b1; tick(1); arm = 1'b0;
    endtask

    task automatic do_clear();
        clr = 1'b1; tick(1); clr = 1'b0;
    endtask

    initial begin
        tick(2);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        check("reset.busy",   64'(busy),   64'd0);
        check("reset.done",   64'(done),   64'd0);
        check("reset.cycles", 64'(cycles), 64'd0);

        bus(1, 1, 1, EOC, 32'h1, 4'hF);
        check("idle_eoc.done", 64'(done), 64'd0);

        do_arm();
        check("arm.busy",    64'(busy),   64'd1);
        check("arm.cycles0", 64'(cycles), 64'd0);
        tick(1);
        check("arm.cycles1", 64'(cycles), 64'd1);
        bus(1, 1, 1, EOC, 32'h1, 4'hF);
        check("eoc1.done", 64'(done),      64'd1);
        check("eoc1.exit", 64'(exit_code), 64'd0);
        check("eoc1.busy", 64'(busy),      64'd0);
        bus(1, 1, 1, EOC, 32'h7, 4'hF);
        check("eoc_again.exit", 64'(exit_code), 64'd0);
        do_arm();
        check("done_arm.busy", 64'(busy), 64'd0);

        do_clear();
        do_arm();
        bus(1, 1, 1, EOC, 32'h55, 4'hF);
        check("eoc42.exit", 64'(exit_code), 64'h2A);
        check("eoc42.done", 64'(done),      64'd1);

        do_clear();
        do_arm();
        bus(1, 1, 1, EOC + 48'd4, 32'h1, 4'hF);
        bus(1, 1, 1, EOC,         32'h1, 4'h0);
        bus(1, 0, 1, EOC,         32'h1, 4'hF);
        bus(1, 1, 0, EOC,         32'h1, 4'hF);
        bus(1, 1, 1, EOC,         32'h2, 4'hF);
        check("ignored.busy",   64'(busy),   64'd1);
        check("ignored.done",   64'(done),   64'd0);
        check("ignored.cycles", 64'(cycles), 64'd5);

        do_clear();
        tmo = 8'd10;
        do_arm();
        tick(9);
        check("wd_n10.timeout", 64'(tout),   64'd0);
        check("wd_n10.cycles",  64'(cycles), 64'd9);
        tick(1);
        check("wd_n11.timeout", 64'(tout),   64'd1);
        check("wd_n11.cycles",  64'(cycles), 64'd9);
        check("wd_n11.busy",    64'(busy),   64'd0);

        do_clear();
        tmo = 8'd0;
        do_arm();
        tick(1000);
        check("wd_off.busy",   64'(busy),   64'd1);
        check("wd_off.cycles", 64'(cycles), 64'd255);

        do_clear();
        tmo = 8'd10;
        do_arm();
        tick(9);
        bus(1, 1, 1, EOC, 32'h0000_0011, 4'hF);
        check("race.done",    64'(done),      64'd1);
        check("race.timeout", 64'(tout),      64'd0);
        check("race.exit",    64'(exit_code), 64'h8);

        clr = 1'b1; arm = 1'b1;
        tick(1);
        clr = 1'b0; arm = 1'b0;
        check("clr_arm.busy",   64'(busy),      64'd0);
        check("clr_arm.done",   64'(done),      64'd0);
        check("clr_arm.exit",   64'(exit_code), 64'd0);
        check("clr_arm.cycles", 64'(cycles),    64'd0);

        tmo = 8'd0;
        do_arm();
        tick(3);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst.busy",   64'(busy),   64'd0);
        check("async_rst.cycles", 64'(cycles), 64'd0);
        @(posedge clk);
        #4;
        rst_n = 1'b1;
        tick(2);
        check("post_rst.busy", 64'(busy), 64'd0);
        do_arm();
        check("rearm.busy", 64'(busy), 64'd1);
        tick(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cheshire_eoc_monitor.md
# cheshire_eoc_monitor

Synthesizable end-of-computation monitor placed directly downstream of the SoC scratch-register write path. It snoops the register-bus write channel and detects the application's exit write, i.e. a write with bit 0 set to the end-of-computation register. It then latches the exit status and flags completion or watchdog timeout. Simulation fixtures and FPGA wrappers read its outputs instead of polling the scratch register over JTAG.

## Interface
- `AddrWidth`, default 48: snooped address width.
- `DataWidth`, default 32: snooped data width; must be ≥ 2.
- `EocAddr`, default 0: byte address of the EOC scratch register; set at instantiation to scratch base + 0x4.
- `CntWidth`, default 32: width of the timeout and cycle counters.
- `clk_i`  in  1  system clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `arm_i`  in  1  single-cycle pulse that starts monitoring.
- `clear_i`  in  1  single-cycle pulse that returns the block to IDLE and clears all status.
- `timeout_cycles_i`  in  CntWidth  watchdog limit; 0 disables the watchdog. Sampled every cycle.
- `snoop_valid_i`  in  1  register-bus request valid.
- `snoop_ready_i`  in  1  register-bus request ready.
- `snoop_write_i`  in  1  request is a write.
- `snoop_addr_i`  in  AddrWidth  request address.
- `snoop_wdata_i`  in  DataWidth  write data.
- `snoop_be_i`  in  DataWidth/8  byte enables.
- `busy_o`  out  1  state is ARMED.
- `done_o`  out  1  EOC seen; sticky until clear.
- `timeout_o`  out  1  watchdog expired; sticky until clear.
- `exit_code_o`  out  DataWidth-1  latched `wdata[DataWidth-1:1]`.
- `cycles_o`  out  CntWidth  cycles spent in ARMED; saturating.

## Operation
- States: IDLE, ARMED, DONE, TIMEOUT. Reset state is IDLE.
- Reset values: every output is 0 and the internal counter is 0.
- A qualifying EOC event requires all of the following in the same cycle:
  - `snoop_valid_i & snoop_ready_i & snoop_write_i`;
  - `snoop_addr_i == EocAddr`, full-width compare, no masking;
  - `snoop_be_i[0] == 1`;
  - `snoop_wdata_i[0] == 1`.
- Writes with `wdata[0] == 0` are ignored. This includes a write of 0 to the EOC register.
- IDLE → ARMED on `arm_i`. On entry, `cycles_o` is set to 0. An EOC event seen in IDLE is ignored.
- ARMED:
  - `cycles_o` increments every cycle and saturates at all-ones.
  - An EOC event moves to DONE, latching `exit_code_o <= snoop_wdata_i[DataWidth-1:1]`.
  - If `timeout_cycles_i != 0` and `cycles_o + 1 >= timeout_cycles_i`, the block moves to TIMEOUT and leaves `exit_code_o` unchanged.
  - If an EOC event and the timeout condition occur in the same cycle, EOC wins and the block goes to DONE.
- DONE and TIMEOUT are terminal:
  - `cycles_o` is frozen.
  - Further EOC events are ignored, so the first exit code is kept.
  - `arm_i` is ignored.
- `clear_i` has the highest priority in every state. The next state is IDLE and all outputs are zeroed, including `exit_code_o` and `cycles_o`.
- If `clear_i` and `arm_i` arrive in the same cycle, clear wins and the result is IDLE.
- `busy_o` is 1 iff the state is ARMED. `done_o` is 1 iff the state is DONE. `timeout_o` is 1 iff the state is TIMEOUT. These are registered decodes of the state.
- The block never drives or stalls the bus; it is purely an observer.

## Timing
- All outputs are registered. There are no combinational paths from inputs to outputs.
- EOC handshake in cycle N → `done_o` and `exit_code_o` are valid from cycle N+1.
- `arm_i` in cycle N → `busy_o = 1` and `cycles_o = 0` in N+1, then `cycles_o = 1` in N+2.
- Timeout with limit T (arm in cycle N) → `timeout_o` rises in cycle N+T+1. At that point `cycles_o` has stopped at T-1.
- `clear_i` in cycle N → all outputs are 0 in N+1.
- Asserting `rst_ni` low at any time, including mid-ARMED, forces IDLE and zero outputs immediately, with no clock required. Release is synchronous to the next edge.

## Test plan
- Reset, then `arm_i`, then an EOC write with `wdata = 0x0000_0001` at `EocAddr`:
  - expected `done_o = 1` one cycle after the handshake, `exit_code_o = 0`, `busy_o = 0`;
  - a following write of `0x0000_0007` leaves `exit_code_o = 0`.
- Armed, then write `0x0000_0055` (exit code 42):
  - expected `exit_code_o = 0x2A` and `done_o = 1`.
- Armed, each of the following alone: write to `EocAddr + 4`, write with `be = 0`, write with `valid = 1` and `ready = 0`, read at `EocAddr`, write of `0x0000_0002`:
  - expected no state change in any case;
  - `cycles_o` keeps counting.
- `timeout_cycles_i = 10`, armed in cycle N, no EOC:
  - expected `timeout_o = 1` in cycle N+11 and `cycles_o = 9`.
  - Repeat with `timeout_cycles_i = 0` for 1000 cycles: expected `busy_o` stays 1.
- `timeout_cycles_i = 10` with a valid EOC handshake in the exact expiry cycle:
  - expected `done_o = 1` and `timeout_o = 0`.
- `clear_i` together with `arm_i` in DONE:
  - expected all outputs 0 and state IDLE next cycle.
- `rst_ni` pulled low mid-ARMED, between clock edges:
  - expected `busy_o = 0` immediately.
